c2f_fabric_if: RTL and testbench
================================

Name: c2f_fabric_if

Overview:
- Core-to-fabric egress stage directly downstream of the gpc_4t C2F request port.
- Buffers C2F requests from the 4-thread core in an in-order FIFO and forwards them to the ring/fabric over a valid/ready handshake.
- Throttles the core through C2F_RspStall.
- Tracks one outstanding read per thread and returns read responses to the core on the C2F response port, tagged with thread ID.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥4).
- STALL_MARGIN, 2, free entries below which C2F_RspStall asserts (covers core stall-reaction latency).
- NUM_THREADS, 4, hardware threads; thread ID width = log2(NUM_THREADS).

Ports:
- QClk  in  1  core clock
- RstQnnnH  in  1  reset
- C2F_ReqValidQ500H  in  1  core request valid
- C2F_ReqOpcodeQ500H  in  2  t_c2f_opcode (RD=2'b00, WR=2'b01, RD_RSP=2'b10, WR_RSP=2'b11)
- C2F_ReqThreadIDQ500H  in  2  issuing thread
- C2F_ReqAddressQ500H  in  32  byte address
- C2F_ReqDataQ500H  in  32  write data
- C2F_RspStall  out  1  backpressure to core
- C2F_RspValidQ502H  out  1  response valid to core
- C2F_RspOpcodeQ502H  out  2  always RD_RSP when valid
- C2F_RspThreadIDQ502H  out  2  response thread
- C2F_RspDataQ502H  out  32  read data
- RingReqValid  out  1  request to fabric valid
- RingReqReady  in  1  fabric accepts request
- RingReqOpcode / RingReqThreadID / RingReqAddress / RingReqData  out  2/2/32/32  head-of-FIFO fields
- RingRspValid  in  1  fabric read response valid (no backpressure)
- RingRspThreadID / RingRspData  in  2/32  response fields
- OverflowErr  out  1  sticky: request dropped on full FIFO
- SpurRspErr  out  1  sticky: response for a thread with no pending read

Behaviour:
- Clocking and reset: one clock, QClk. RstQnnnH is synchronous, active-high. While reset is asserted:
  - count, pointers, pending bits and error flags clear.
  - All outputs are 0. C2F_RspStall is 0.
  - A reset mid-transaction discards all FIFO entries and pending reads. No response is generated for them.
- Push: occurs when C2F_ReqValidQ500H && (count<DEPTH || pop). Opcodes RD and WR are stored. Requests with RD_RSP/WR_RSP opcodes are ignored and set no flag.
- Full push: a push arriving with count==DEPTH and no pop is dropped and OverflowErr sets. OverflowErr stays set until reset.
- Enqueue latency: a request pushed in cycle t is presented on Ring* in cycle t+1 at the earliest (registered FIFO storage).
- Head presentation: RingReqValid = !empty && !(head is RD && pending[head thread]). A blocked head read stalls all younger entries (strict order).
- Pop: occurs when RingReqValid && RingReqReady.
  - Popping an RD sets pending[thread] at the end of that cycle.
  - WR is posted; no response is tracked.
- Fabric hold: Ring* outputs stay stable while RingReqValid && !RingReqReady.
- Count: count' = count + push − pop. Simultaneous push and pop at full leaves count at DEPTH. Pointers wrap modulo DEPTH.
- Stall: C2F_RspStall = (DEPTH − count') < STALL_MARGIN. It is registered, so it reflects the post-update occupancy in the next cycle. With the defaults it asserts at count ≥3.
- Response path: RingRspValid at cycle t produces C2F_RspValidQ502H=1 at t+1 for exactly one cycle, with the thread ID and data registered and opcode RD_RSP. pending[thread] clears at the end of cycle t.
- Same-cycle pop and response: a pop of an RD and a response for the same thread in the same cycle leaves pending set (the set wins; the response clears the older read).
- Spurious response: RingRspValid for a thread with pending==0 is dropped. No C2F response is generated and SpurRspErr sets (sticky).
- Idle outputs: C2F response outputs are 0 when C2F_RspValidQ502H is 0.

Decomposition:
- lotr_pkg holds:
  - t_c2f_opcode enum
  - t_c2f_req struct {opcode, thread_id, address, data}
  - localparams C2F_ADRS_W=32, C2F_DATA_W=32, TID_W=2
- Sub-module lotr_sync_fifo: generic DEPTH × t_c2f_req with push/pop/count/full/empty outputs. Pending tracking, stall and the response register stay in the top module.

Test Plan:
- Single WR, thread 1, address 0x0000_0400, data 0xDEAD_BEEF, RingReqReady=1 → RingReqValid high the next cycle with the same fields. No C2F response. Pending bits stay 0.
- RD, thread 2, address 0x100 popped; RingRsp for thread 2 with data 0x1234_5678 three cycles later → C2F_RspValidQ502H one cycle after RingRspValid, with TID=2, opcode RD_RSP, data 0x1234_5678.
- RingReqReady=0 with 5 consecutive pushes → C2F_RspStall rises after the 3rd push, count saturates at 4, the 5th push is dropped, OverflowErr=1. Raising ready then drains 4 entries in order.
- Two RDs from thread 0 back-to-back → the 2nd stays at head with RingReqValid=0 until the response for thread 0 arrives, then issues the next cycle.
- RingRspValid for thread 3 with no pending read → no C2F response, SpurRspErr=1.
- Reset asserted with 3 entries queued and 1 read pending → next cycle count=0, RingReqValid=0, C2F_RspStall=0, no response emitted afterwards.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared types and widths for the core-to-fabric (C2F) request and response path.
package lotr_pkg;

    localparam int C2F_ADRS_W = 32;
    localparam int C2F_DATA_W = 32;
    localparam int TID_W      = 2;

    typedef enum logic [1:0] {
        C2F_RD     = 2'b00,
        C2F_WR     = 2'b01,
        C2F_RD_RSP = 2'b10,
        C2F_WR_RSP = 2'b11
    } t_c2f_opcode;

    typedef struct packed {
        t_c2f_opcode             opcode;
        logic [TID_W-1:0]        thread_id;
        logic [C2F_ADRS_W-1:0]   address;
        logic [C2F_DATA_W-1:0]   data;
    } t_c2f_req;

    // Only RD and WR travel to the fabric; response opcodes from the core are ignored.
    function automatic logic is_mem_op(input t_c2f_opcode op);
        return (op == C2F_RD) || (op == C2F_WR);
    endfunction

endpackage

// File: rtl/lotr_sync_fifo.sv
// In-order synchronous FIFO of C2F requests with registered storage.
// The caller guarantees no push when full without a pop, and no pop when empty.
module lotr_sync_fifo
    import lotr_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  t_c2f_req         push_data_i,
    input  logic             pop_i,
    output t_c2f_req         head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    t_c2f_req         mem_q [DEPTH];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/c2f_fabric_if.sv
// Core-to-fabric egress: buffers core requests, issues them in order to the ring,
// throttles the core and returns read responses tagged by thread.
module c2f_fabric_if
    import lotr_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2,
    parameter int NUM_THREADS  = 4
) (
    input  logic                  QClk,
    input  logic                  RstQnnnH,
    input  logic                  C2F_ReqValidQ500H,
    input  logic [1:0]            C2F_ReqOpcodeQ500H,
    input  logic [TID_W-1:0]      C2F_ReqThreadIDQ500H,
    input  logic [C2F_ADRS_W-1:0] C2F_ReqAddressQ500H,
    input  logic [C2F_DATA_W-1:0] C2F_ReqDataQ500H,
    output logic                  C2F_RspStall,
    output logic                  C2F_RspValidQ502H,
    output logic [1:0]            C2F_RspOpcodeQ502H,
    output logic [TID_W-1:0]      C2F_RspThreadIDQ502H,
    output logic [C2F_DATA_W-1:0] C2F_RspDataQ502H,
    output logic                  RingReqValid,
    input  logic                  RingReqReady,
    output logic [1:0]            RingReqOpcode,
    output logic [TID_W-1:0]      RingReqThreadID,
    output logic [C2F_ADRS_W-1:0] RingReqAddress,
    output logic [C2F_DATA_W-1:0] RingReqData,
    input  logic                  RingRspValid,
    input  logic [TID_W-1:0]      RingRspThreadID,
    input  logic [C2F_DATA_W-1:0] RingRspData,
    output logic                  OverflowErr,
    output logic                  SpurRspErr
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(STALL_MARGIN);

    t_c2f_req         req_in;
    t_c2f_req         fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_is_mem;
    logic             head_present;
    logic             head_blocked;
    logic             push;
    logic             pop;
    logic             rsp_hit;

    logic [NUM_THREADS-1:0] pending_q, pending_d;
    logic                   stall_q, stall_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [1:0]             rsp_opcode_q, rsp_opcode_d;
    logic [TID_W-1:0]       rsp_tid_q, rsp_tid_d;
    logic [C2F_DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic                   ovf_q, ovf_d;
    logic                   spur_q, spur_d;

    assign req_in = '{opcode:    t_c2f_opcode'(C2F_ReqOpcodeQ500H),
                      thread_id: C2F_ReqThreadIDQ500H,
                      address:   C2F_ReqAddressQ500H,
                      data:      C2F_ReqDataQ500H};

    // A head read waits while its thread still has a read in flight; younger entries wait behind it.
    assign head_present = !RstQnnnH && !fifo_empty;
    assign head_blocked = (fifo_head.opcode == C2F_RD) && pending_q[fifo_head.thread_id];
    assign RingReqValid = head_present && !head_blocked;
    assign pop          = RingReqValid && RingReqReady;

    assign req_is_mem = C2F_ReqValidQ500H && is_mem_op(req_in.opcode);
    assign push       = req_is_mem && (!fifo_full || pop);
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign rsp_hit    = RingRspValid && pending_q[RingRspThreadID];

    lotr_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (QClk),
        .rst_i       (RstQnnnH),
        .push_i      (push),
        .push_data_i (req_in),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        // The response clears first so a same-cycle read issue for that thread keeps it pending.
        pending_d = pending_q;
        if (rsp_hit)                                pending_d[RingRspThreadID]    = 1'b0;
        if (pop && (fifo_head.opcode == C2F_RD))    pending_d[fifo_head.thread_id] = 1'b1;

        stall_d      = (DEPTH_C - count_next) < MARGIN_C;
        rsp_valid_d  = rsp_hit;
        rsp_opcode_d = rsp_hit ? C2F_RD_RSP : 2'b00;
        rsp_tid_d    = rsp_hit ? RingRspThreadID : '0;
        rsp_data_d   = rsp_hit ? RingRspData : '0;
        ovf_d        = ovf_q  | (req_is_mem && fifo_full && !pop);
        spur_d       = spur_q | (RingRspValid && !pending_q[RingRspThreadID]);
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            pending_q    <= '0;
            stall_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_opcode_q <= 2'b00;
            rsp_tid_q    <= '0;
            rsp_data_q   <= '0;
            ovf_q        <= 1'b0;
            spur_q       <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            stall_q      <= stall_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_tid_q    <= rsp_tid_d;
            rsp_data_q   <= rsp_data_d;
            ovf_q        <= ovf_d;
            spur_q       <= spur_d;
        end
    end

    assign RingReqOpcode   = head_present ? fifo_head.opcode    : 2'b00;
    assign RingReqThreadID = head_present ? fifo_head.thread_id : '0;
    assign RingReqAddress  = head_present ? fifo_head.address   : '0;
    assign RingReqData     = head_present ? fifo_head.data      : '0;

    assign C2F_RspStall         = stall_q;
    assign C2F_RspValidQ502H    = rsp_valid_q;
    assign C2F_RspOpcodeQ502H   = rsp_opcode_q;
    assign C2F_RspThreadIDQ502H = rsp_tid_q;
    assign C2F_RspDataQ502H     = rsp_data_q;
    assign OverflowErr          = ovf_q;
    assign SpurRspErr           = spur_q;

endmodule

// File: tb/tb_c2f_fabric_if.sv
// Directed plus randomized bench for c2f_fabric_if against a queue-based reference model.
module tb_c2f_fabric_if;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [1:0]  req_tid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        stall;
    logic        rsp_v_o;
    logic [1:0]  rsp_op_o;
    logic [1:0]  rsp_tid_o;
    logic [31:0] rsp_data_o;
    logic        ring_valid;
    logic        ring_ready;
    logic [1:0]  ring_op;
    logic [1:0]  ring_tid;
    logic [31:0] ring_addr;
    logic [31:0] ring_data;
    logic        rrsp_valid;
    logic [1:0]  rrsp_tid;
    logic [31:0] rrsp_data;
    logic        ovf;
    logic        spur;

    always #5 clk = ~clk;

    c2f_fabric_if dut (
        .QClk                 (clk),
        .RstQnnnH             (rst),
        .C2F_ReqValidQ500H    (req_valid),
        .C2F_ReqOpcodeQ500H   (req_op),
        .C2F_ReqThreadIDQ500H (req_tid),
        .C2F_ReqAddressQ500H  (req_addr),
        .C2F_ReqDataQ500H     (req_data),
        .C2F_RspStall         (stall),
        .C2F_RspValidQ502H    (rsp_v_o),
        .C2F_RspOpcodeQ502H   (rsp_op_o),
        .C2F_RspThreadIDQ502H (rsp_tid_o),
        .C2F_RspDataQ502H     (rsp_data_o),
        .RingReqValid         (ring_valid),
        .RingReqReady         (ring_ready),
        .RingReqOpcode        (ring_op),
        .RingReqThreadID      (ring_tid),
        .RingReqAddress       (ring_addr),
        .RingReqData          (ring_data),
        .RingRspValid         (rrsp_valid),
        .RingRspThreadID      (rrsp_tid),
        .RingRspData          (rrsp_data),
        .OverflowErr          (ovf),
        .SpurRspErr           (spur)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  tid;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        mq[$];
    logic [3:0]  mpend;
    logic        m_ovf, m_spur, m_stall, m_rsp_v;
    logic [1:0]  m_rsp_tid;
    logic [31:0] m_rsp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_head_issuable();
        if (rst || mq.size() == 0) return 1'b0;
        return !(mq[0].op == 2'b00 && mpend[mq[0].tid]);
    endfunction

    task automatic check_ring();
        logic present;
        present = !rst && (mq.size() > 0);
        check("ring_valid", ring_valid, model_head_issuable());
        if (present) begin
            check("ring_op",   ring_op,   mq[0].op);
            check("ring_tid",  ring_tid,  mq[0].tid);
            check("ring_addr", ring_addr, mq[0].addr);
            check("ring_data", ring_data, mq[0].data);
        end else begin
            check("ring_op_idle",   ring_op,   0);
            check("ring_addr_idle", ring_addr, 0);
        end
    endtask

    task automatic model_step();
        logic       pop, isop, push;
        logic [3:0] np;
        m_rsp_v    = 1'b0;
        m_rsp_tid  = 2'd0;
        m_rsp_data = 32'd0;
        if (rst) begin
            mq.delete();
            mpend   = 4'd0;
            m_ovf   = 1'b0;
            m_spur  = 1'b0;
            m_stall = 1'b0;
            return;
        end
        pop  = model_head_issuable() && ring_ready;
        isop = req_valid && (req_op == 2'b00 || req_op == 2'b01);
        push = isop && (mq.size() < DEPTH || pop);
        if (isop && !push) m_ovf = 1'b1;
        np = mpend;
        if (rrsp_valid) begin
            if (mpend[rrsp_tid]) begin
                m_rsp_v       = 1'b1;
                m_rsp_tid     = rrsp_tid;
                m_rsp_data    = rrsp_data;
                np[rrsp_tid]  = 1'b0;
            end else begin
                m_spur = 1'b1;
            end
        end
        if (pop) begin
            if (mq[0].op == 2'b00) np[mq[0].tid] = 1'b1;
            void'(mq.pop_front());
        end
        if (push) mq.push_back('{req_op, req_tid, req_addr, req_data});
        mpend   = np;
        m_stall = (DEPTH - mq.size()) < MARGIN;
    endtask

    task automatic check_post();
        check("stall",    stall,      m_stall);
        check("rsp_v",    rsp_v_o,    m_rsp_v);
        check("rsp_op",   rsp_op_o,   m_rsp_v ? 2'b10 : 2'b00);
        check("rsp_tid",  rsp_tid_o,  m_rsp_tid);
        check("rsp_data", rsp_data_o, m_rsp_data);
        check("ovf",      ovf,        m_ovf);
        check("spur",     spur,       m_spur);
    endtask

    // Inputs are applied 1 time unit after a rising edge; tick checks, advances model and DUT by one edge.
    task automatic tick();
        #1;
        check_ring();
        model_step();
        @(posedge clk);
        #1;
        check_post();
    endtask

    task automatic req(input logic [1:0] op, input logic [1:0] tid,
                       input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_tid   = tid;
        req_addr  = addr;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rsp(input logic [1:0] tid, input logic [31:0] data);
        rrsp_valid = 1'b1;
        rrsp_tid   = tid;
        rrsp_data  = data;
        tick();
        rrsp_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_tid    = 2'd0;
        req_addr   = 32'd0;
        req_data   = 32'd0;
        ring_ready = 1'b1;
        rrsp_valid = 1'b0;
        rrsp_tid   = 2'd0;
        rrsp_data  = 32'd0;
        mpend      = 4'd0;
        m_ovf      = 1'b0;
        m_spur     = 1'b0;
        m_stall    = 1'b0;
        @(posedge clk);
        #1;
        tick();
        check("reset_stall", stall, 0);
        check("reset_ring_valid", ring_valid, 0);
        rst = 1'b0;

        // Single posted write appears on the ring the next cycle.
        req(2'b01, 2'd1, 32'h0000_0400, 32'hDEAD_BEEF);
        check("wr_ring_valid", ring_valid, 1);
        check("wr_ring_addr",  ring_addr,  32'h0000_0400);
        check("wr_ring_data",  ring_data,  32'hDEAD_BEEF);
        check("wr_ring_tid",   ring_tid,   2'd1);
        tick();
        tick();
        check("wr_no_rsp", rsp_v_o, 0);

        // Read on thread 2, response three cycles after issue.
        req(2'b00, 2'd2, 32'h0000_0100, 32'h0);
        check("rd_ring_op", ring_op, 2'b00);
        tick();
        tick();
        tick();
        rsp(2'd2, 32'h1234_5678);
        check("rd_rsp_valid", rsp_v_o,    1);
        check("rd_rsp_tid",   rsp_tid_o,  2'd2);
        check("rd_rsp_op",    rsp_op_o,   2'b10);
        check("rd_rsp_data",  rsp_data_o, 32'h1234_5678);
        tick();
        check("rd_rsp_one_cycle", rsp_v_o, 0);

        // Backpressure: five pushes into a blocked fabric.
        ring_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(2'b01, 2'(i), 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            check("fill_stall", stall, (i >= 2) ? 1 : 0);
            check("fill_ovf",   ovf,   (i >= 4) ? 1 : 0);
        end
        ring_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", ring_addr, 32'h0000_1000 + 32'(i * 4));
            tick();
        end
        check("drained_valid", ring_valid, 0);

        // Second read from the same thread waits for the first response.
        req(2'b00, 2'd0, 32'h0000_0200, 32'h0);
        req(2'b00, 2'd0, 32'h0000_0204, 32'h0);
        check("rd_blocked_valid", ring_valid, 0);
        check("rd_blocked_addr",  ring_addr,  32'h0000_0204);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_still_blocked", ring_valid, 0);
        end
        rsp(2'd0, 32'hAAAA_5555);
        check("rd_unblocked", ring_valid, 1);
        tick();
        rsp(2'd0, 32'h5555_AAAA);

        // Response for a thread with nothing outstanding.
        rsp(2'd3, 32'hCAFE_F00D);
        check("spur_no_rsp", rsp_v_o, 0);
        check("spur_flag",   spur,    1);

        // Reset with queued entries and one read in flight.
        req(2'b00, 2'd1, 32'h0000_0300, 32'h0);
        tick();
        ring_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(2'b01, 2'd2, 32'h0000_0400 + 32'(i), 32'(i));
        rst = 1'b1;
        tick();
        check("rst_ring_valid", ring_valid, 0);
        check("rst_stall",      stall,      0);
        check("rst_ovf",        ovf,        0);
        check("rst_spur",       spur,       0);
        rst = 1'b0;
        ring_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_rsp", rsp_v_o, 0);
        end

        // Randomized traffic; the fabric mostly answers threads that have a read in flight.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] t;
            ring_ready = ($urandom_range(0, 3) != 0);
            req_valid  = ($urandom_range(0, 1) == 1);
            req_op     = 2'($urandom_range(0, 3));
            req_tid    = 2'($urandom_range(0, 3));
            req_addr   = $urandom;
            req_data   = $urandom;
            rrsp_valid = ($urandom_range(0, 3) == 0);
            t = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (mpend[2'(t + 2'(k))]) begin
                        t = 2'(t + 2'(k));
                        break;
                    end
                end
            end
            rrsp_tid  = t;
            rrsp_data = $urandom;
            tick();
        end
        req_valid  = 1'b0;
        rrsp_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
